// File: rtl/pa_clic_arb_pkg.sv
// ============================================================================
// Module : pa_clic_arb_pkg
// Brief  : Shared candidate type and priority-compare rule for the CLIC arbiter
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pa_clic_arb_pkg;

  localparam int PRIO_W_MAX = 9;   // {mode, up to 8 level bits}
  localparam int ID_W_MAX   = 16;
  localparam int IL_WIDTH   = 8;

  // Sized for the widest legal configuration; narrower builds zero the MSBs.
  typedef struct packed {
    logic                  req;
    logic [PRIO_W_MAX-1:0] prio;
    logic                  hv;
    logic [ID_W_MAX-1:0]   id;
  } clic_cand_t;

  localparam int CAND_W = $bits(clic_cand_t);

  function automatic logic cand_wins(input clic_cand_t a, input clic_cand_t b);
    return a.req & (~b.req | (a.prio > b.prio) |
                    ((a.prio == b.prio) & (a.id < b.id)));
  endfunction

endpackage

`default_nettype wire

// File: rtl/pa_clic_arb_tree.sv
// ============================================================================
// Module : pa_clic_arb_tree
// Brief  : Combinational tournament reduction of N candidates to one winner
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pa_clic_arb_tree
  import pa_clic_arb_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N*CAND_W-1:0] i_cand,
  output clic_cand_t          o_win
);

  // Heap layout: leaves at [N-1 .. 2N-2], node k has children 2k+1 and 2k+2.
  clic_cand_t w_node [2*N-1];

  always_comb begin
    for (int j = 0; j < N; j++) begin
      w_node[N-1+j] = i_cand[j*CAND_W +: CAND_W];
    end
    for (int k = N-2; k >= 0; k--) begin
      w_node[k] = cand_wins(w_node[2*k+1], w_node[2*k+2]) ? w_node[2*k+1]
                                                            : w_node[2*k+2];
    end
  end

  assign o_win = w_node[0];

endmodule

`default_nettype wire

// File: rtl/pa_clic_arb_pipe.sv
// ============================================================================
// Module : pa_clic_arb_pipe
// Brief  : Two-stage pipelined CLIC arbiter with freeze/flush and change pulse.
//          Optional macro CLIC_ARB_THRESH_EN adds threshold gating of vld.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pa_clic_arb_pipe
  import pa_clic_arb_pkg::*;
#(
  parameter int INT_NUM  = 64,
  parameter int CTLBITS  = 3,
  parameter int GRP_SIZE = 16,
  parameter int ID_WIDTH = 12
) (
  input  logic                           clic_clk,
  input  logic                           cpurst_b,
  input  logic [INT_NUM-1:0]             kid_arb_int_req,
  input  logic [INT_NUM-1:0]             kid_arb_int_hv,
  input  logic [(CTLBITS+1)*INT_NUM-1:0] kid_arb_int_all_vec,
  input  logic [CTLBITS-1:0]             ctrl_xx_int_lv_or_mask,
  input  logic                           ctrl_arb_freeze,
  input  logic                           ctrl_arb_flush,
`ifdef CLIC_ARB_THRESH_EN
  input  logic [IL_WIDTH-1:0]            ctrl_arb_int_thresh,
`endif
  output logic                           arb_ctrl_int_vld,
  output logic [ID_WIDTH-1:0]            arb_ctrl_int_id,
  output logic [IL_WIDTH-1:0]            arb_ctrl_int_il,
  output logic                           arb_ctrl_int_mode,
  output logic                           arb_ctrl_int_hv,
  output logic                           arb_ctrl_int_chg,
  output logic                           arb_ctrl_int_req_raw
);

  localparam int NGRP = INT_NUM / GRP_SIZE;
  localparam int VW   = CTLBITS + 1;

  logic [INT_NUM*CAND_W-1:0] w_leaf;
  logic [NGRP*CAND_W-1:0]    w_grp_win;
  logic [NGRP*CAND_W-1:0]    r_s1;
  clic_cand_t                r_s2;
  logic [IL_WIDTH-1:0]       r_il;
  logic                      r_chg;

  // Idle channels are zeroed so an empty result is all-zero (id=0, il=0).
  for (genvar i = 0; i < INT_NUM; i++) begin : g_leaf
    clic_cand_t w_c;
    always_comb begin
      w_c = '0;
      if (kid_arb_int_req[i]) begin
        w_c.req  = 1'b1;
        w_c.prio = PRIO_W_MAX'(kid_arb_int_all_vec[VW*i +: VW]);
        w_c.hv   = kid_arb_int_hv[i];
        w_c.id   = ID_W_MAX'(i);
      end
    end
    assign w_leaf[i*CAND_W +: CAND_W] = w_c;
  end

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    clic_cand_t w_gw;
    pa_clic_arb_tree #(.N(GRP_SIZE)) u_tree (
      .i_cand (w_leaf[g*GRP_SIZE*CAND_W +: GRP_SIZE*CAND_W]),
      .o_win  (w_gw)
    );
    assign w_grp_win[g*CAND_W +: CAND_W] = w_gw;
  end

  clic_cand_t w_win;
  pa_clic_arb_tree #(.N(NGRP)) u_tree_s2 (
    .i_cand (r_s1),
    .o_win  (w_win)
  );

  logic [CTLBITS-1:0]  w_lv;
  logic [IL_WIDTH-1:0] w_il;

  assign w_lv = w_win.prio[CTLBITS-1:0] |
                (ctrl_xx_int_lv_or_mask & {CTLBITS{w_win.req}});

  if (CTLBITS == IL_WIDTH) begin : g_il_full
    assign w_il = w_lv;
  end else begin : g_il_fill
    assign w_il = {w_lv, {(IL_WIDTH-CTLBITS){w_win.req}}};
  end

  logic w_vld;
`ifdef CLIC_ARB_THRESH_EN
  assign w_vld = w_win.req & (w_il > ctrl_arb_int_thresh);
`else
  assign w_vld = w_win.req;
`endif

  clic_cand_t w_s2_nxt;
  always_comb begin
    w_s2_nxt     = w_win;
    w_s2_nxt.req = w_vld;
  end

  // hv is deliberately excluded from change detection.
  logic w_chg_load;
  logic w_chg_flush;
  assign w_chg_load  = {w_s2_nxt.req, w_s2_nxt.id, w_s2_nxt.prio} !=
                       {r_s2.req, r_s2.id, r_s2.prio};
  assign w_chg_flush = {r_s2.req, r_s2.id, r_s2.prio} != '0;

  always_ff @(posedge clic_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_il  <= '0;
      r_chg <= 1'b0;
    end else if (ctrl_arb_flush) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_il  <= '0;
      r_chg <= w_chg_flush;
    end else begin
      r_s1 <= w_grp_win;
      if (ctrl_arb_freeze) begin
        r_chg <= 1'b0;
      end else begin
        r_s2  <= w_s2_nxt;
        r_il  <= w_il;
        r_chg <= w_chg_load;
      end
    end
  end

  assign arb_ctrl_int_vld     = r_s2.req;
  assign arb_ctrl_int_id      = r_s2.id[ID_WIDTH-1:0];
  assign arb_ctrl_int_il      = r_il;
  assign arb_ctrl_int_mode    = r_s2.prio[CTLBITS];
  assign arb_ctrl_int_hv      = r_s2.hv;
  assign arb_ctrl_int_chg     = r_chg;
  assign arb_ctrl_int_req_raw = |kid_arb_int_req;

endmodule

`default_nettype wire
